// File: rtl/booth_job_sequencer_if.sv
// Bundles the operand, multiplier and result signals of booth_job_sequencer.
// master = the sequencer itself, slave = its environment (feeder, multiplier, consumer).
interface booth_job_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_start;
    logic        mul_done;
    logic [63:0] mul_product;
    logic [4:0]  mul_addcnt;
    logic [4:0]  mul_subcnt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic [4:0]  out_addcnt;
    logic [4:0]  out_subcnt;
    logic        out_timeout;
    logic        busy;

    modport master (
        input  in_valid, in_a, in_b, mul_done, mul_product, mul_addcnt, mul_subcnt, out_ready,
        output in_ready, mul_a, mul_b, mul_start, out_valid, out_product, out_addcnt,
               out_subcnt, out_timeout, busy
    );

    modport slave (
        output in_valid, in_a, in_b, mul_done, mul_product, mul_addcnt, mul_subcnt, out_ready,
        input  in_ready, mul_a, mul_b, mul_start, out_valid, out_product, out_addcnt,
               out_subcnt, out_timeout, busy
    );
endinterface

// File: rtl/booth_job_sequencer.sv
// Buffers operand pairs, runs one Booth multiply at a time and returns the result on valid/ready.
// Define BOOTH_SEQ_STATS_EN to add the saturating job/add/sub/timeout statistics outputs.
module booth_job_sequencer #(
    parameter int DEPTH          = 4,
    parameter int START_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_job_sequencer_if.master bus
`ifdef BOOTH_SEQ_STATS_EN
    ,
    output logic [15:0]           stat_jobs,
    output logic [15:0]           stat_adds,
    output logic [15:0]           stat_subs,
    output logic [7:0]            stat_timeouts
`endif
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_OUTPUT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [2:0]  r_start_cnt;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_out_valid;
    logic        r_out_timeout;
    logic [63:0] r_out_product;
    logic [4:0]  r_out_addcnt;
    logic [4:0]  r_out_subcnt;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_capture;
    logic        w_abort;
    logic        w_handshake;
    logic        w_start_done;
    logic        w_wait_expired;
    logic        w_in_wait;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign w_empty        = (r_wr_ptr == r_rd_ptr);
    assign w_full         = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push         = bus.in_valid && !w_full;
    assign w_pop          = (r_state == S_IDLE) && !w_empty;
    assign w_handshake    = r_out_valid && bus.out_ready;
    assign w_start_done   = (r_start_cnt == 3'(START_CYCLES - 1));
    assign w_wait_expired = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign w_in_wait      = (r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH);

    // NOTE: the storage array has no reset; entries are only meaningful between the pointers, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {bus.in_a, bus.in_b};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (w_start_done) w_next = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!bus.mul_done) begin
                    w_next = S_WAIT_HIGH;
                end else if (w_wait_expired) begin
                    w_next  = S_OUTPUT;
                    w_abort = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (bus.mul_done) begin
                    w_next    = S_OUTPUT;
                    w_capture = 1'b1;
                end else if (w_wait_expired) begin
                    w_next  = S_OUTPUT;
                    w_abort = 1'b1;
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Both counters restart whenever their state is (re)entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_start_cnt <= ((r_state == S_LAUNCH) && (w_next == S_LAUNCH)) ? r_start_cnt + 3'd1 : 3'd0;
            r_wait_cnt  <= (w_in_wait && (w_next == r_state)) ? r_wait_cnt + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_out_valid   <= 1'b0;
            r_out_timeout <= 1'b0;
            r_out_product <= '0;
            r_out_addcnt  <= '0;
            r_out_subcnt  <= '0;
        end else begin
            if (w_pop) begin
                {r_mul_a, r_mul_b} <= r_mem[r_rd_ptr[AW-1:0]];
            end
            if (w_capture) begin
                r_out_valid   <= 1'b1;
                r_out_timeout <= 1'b0;
                r_out_product <= bus.mul_product;
                r_out_addcnt  <= bus.mul_addcnt;
                r_out_subcnt  <= bus.mul_subcnt;
            end else if (w_abort) begin
                r_out_valid   <= 1'b1;
                r_out_timeout <= 1'b1;
                r_out_product <= '0;
                r_out_addcnt  <= '0;
                r_out_subcnt  <= '0;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = !w_full;
    assign bus.mul_a       = r_mul_a;
    assign bus.mul_b       = r_mul_b;
    assign bus.mul_start   = (r_state == S_LAUNCH);
    assign bus.out_valid   = r_out_valid;
    assign bus.out_product = r_out_product;
    assign bus.out_addcnt  = r_out_addcnt;
    assign bus.out_subcnt  = r_out_subcnt;
    assign bus.out_timeout = r_out_timeout;
    assign bus.busy        = (r_state != S_IDLE);

`ifdef BOOTH_SEQ_STATS_EN
    logic [15:0] r_stat_jobs;
    logic [15:0] r_stat_adds;
    logic [15:0] r_stat_subs;
    logic [7:0]  r_stat_timeouts;
    logic [16:0] w_adds_sum;
    logic [16:0] w_subs_sum;

    assign w_adds_sum = {1'b0, r_stat_adds} + 17'(r_out_addcnt);
    assign w_subs_sum = {1'b0, r_stat_subs} + 17'(r_out_subcnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_jobs     <= '0;
            r_stat_adds     <= '0;
            r_stat_subs     <= '0;
            r_stat_timeouts <= '0;
        end else if (w_handshake) begin
            if (r_stat_jobs != '1) r_stat_jobs <= r_stat_jobs + 16'd1;
            r_stat_adds <= w_adds_sum[16] ? '1 : w_adds_sum[15:0];
            r_stat_subs <= w_subs_sum[16] ? '1 : w_subs_sum[15:0];
            if (r_out_timeout && (r_stat_timeouts != '1)) r_stat_timeouts <= r_stat_timeouts + 8'd1;
        end
    end

    assign stat_jobs     = r_stat_jobs;
    assign stat_adds     = r_stat_adds;
    assign stat_subs     = r_stat_subs;
    assign stat_timeouts = r_stat_timeouts;
`endif
endmodule

// File: tb/tb_booth_job_sequencer.sv
// Self-checking bench for booth_job_sequencer: a behavioural radix-2 Booth multiplier on the
// mul_* side, a scoreboard of expected results, and a negedge monitor on the result port.
module tb_booth_job_sequencer;
    localparam int DEPTH          = 4;
    localparam int START_CYCLES   = 1;
    localparam int TIMEOUT_CYCLES = 64;

    typedef struct packed {
        logic [63:0] p;
        logic [4:0]  add;
        logic [4:0]  sub;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    booth_job_sequencer_if bus ();

`ifdef BOOTH_SEQ_STATS_EN
    logic [15:0] stat_jobs;
    logic [15:0] stat_adds;
    logic [15:0] stat_subs;
    logic [7:0]  stat_timeouts;
`endif

    booth_job_sequencer #(
        .DEPTH          (DEPTH),
        .START_CYCLES   (START_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BOOTH_SEQ_STATS_EN
        ,
        .stat_jobs     (stat_jobs),
        .stat_adds     (stat_adds),
        .stat_subs     (stat_subs),
        .stat_timeouts (stat_timeouts)
`endif
    );

    // Behavioural sequential Booth multiplier: one bit pair per cycle, never reset.
    logic        m_done = 1'b1;
    logic        m_run  = 1'b0;
    logic [5:0]  m_step = '0;
    logic [63:0] m_prod = '0;
    logic [4:0]  m_add  = '0;
    logic [4:0]  m_sub  = '0;
    logic        stub_done_high = 1'b0;
    wire  [1:0]  m_pair = {bus.mul_b[m_step[4:0]], (m_step == 6'd0) ? 1'b0 : bus.mul_b[m_step[4:0] - 5'd1]};
    wire  [63:0] m_term = {{32{bus.mul_a[31]}}, bus.mul_a} << m_step;

    always @(posedge clk) begin
        if (bus.mul_start) begin
            m_run  <= 1'b1;
            m_step <= '0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_add  <= '0;
            m_sub  <= '0;
        end else if (m_run) begin
            if (m_pair == 2'b10) begin
                m_prod <= m_prod - m_term;
                m_sub  <= m_sub + 5'd1;
            end else if (m_pair == 2'b01) begin
                m_prod <= m_prod + m_term;
                m_add  <= m_add + 5'd1;
            end
            if (m_step == 6'd31) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
            end
            m_step <= m_step + 6'd1;
        end
    end

    assign bus.mul_done    = stub_done_high ? 1'b1 : m_done;
    assign bus.mul_product = m_prod;
    assign bus.mul_addcnt  = m_add;
    assign bus.mul_subcnt  = m_sub;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pushed  = 0;
    int   n_results = 0;
    logic prev_hs   = 1'b0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic prev;
        prev  = 1'b0;
        e.p   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        e.add = '0;
        e.sub = '0;
        e.to  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (b[i] && !prev) e.sub = e.sub + 5'd1;
            else if (!b[i] && prev) e.add = e.add + 5'd1;
            prev = b[i];
        end
        return e;
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int k;
        k = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check("push_ready", 64'(bus.in_ready), 64'(1));
        if (bus.in_ready) begin
            sb_q.push_back(e);
            n_pushed++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_all(input string tag, input int budget);
        int k;
        k = 0;
        while (n_results < n_pushed && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 64'(n_results), 64'(n_pushed));
    endtask

    // Result monitor: scoreboard compare on every handshake, then one idle cycle before any launch.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (prev_hs) check("idle_gap_start", 64'(bus.mul_start), 64'(0));
            prev_hs = rst_n && bus.out_valid && bus.out_ready;
            if (prev_hs) begin
                check("sb_has_entry", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("out_product", bus.out_product, e.p);
                    check("out_addcnt", 64'(bus.out_addcnt), 64'(e.add));
                    check("out_subcnt", 64'(bus.out_subcnt), 64'(e.sub));
                    check("out_timeout", 64'(bus.out_timeout), 64'(e.to));
                end
                n_results++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va [5];
        logic [31:0] vb [5];
        int          k;
        int          bad;
        int          starts;
        int          dwell;

        va = '{32'd123, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h5555_5555};
        vb = '{32'hFFFF_FE38, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_mul_start", 64'(bus.mul_start), 64'(0));
        check("rst_out_product", bus.out_product, 64'(0));
        check("rst_out_timeout", 64'(bus.out_timeout), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        // Single jobs with hand-derived results.
        push(32'd7, 32'hFFFF_FFFD, '{64'hFFFF_FFFF_FFFF_FFEB, 5'd1, 5'd2, 1'b0});
        wait_all("job_7x-3_done", 200);
        push(32'd5, 32'd6, '{64'd30, 5'd1, 5'd1, 1'b0});
        wait_all("job_5x6_done", 200);

        // Five back-to-back pushes into a four-entry FIFO while the first job is running.
        for (int i = 0; i < 5; i++) push(va[i], vb[i], expect_of(va[i], vb[i]));
        check("fifo_full_in_ready", 64'(bus.in_ready), 64'(0));
        wait_all("burst_done", 600);

        // Back-pressure: result must be held and no new launch may occur.
        bus.out_ready = 1'b0;
        push(32'd9, 32'hFFFF_FFF7, expect_of(32'd9, 32'hFFFF_FFF7));
        push(32'hFFFF_FF9C, 32'd77, expect_of(32'hFFFF_FF9C, 32'd77));
        k = 0;
        while (!bus.out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("hold_valid_seen", 64'(bus.out_valid), 64'(1));
        bad    = 0;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_product !== sb_q[0].p ||
                bus.out_addcnt !== sb_q[0].add || bus.out_subcnt !== sb_q[0].sub ||
                bus.out_timeout !== 1'b0) bad++;
            if (bus.mul_start) starts++;
            @(posedge clk); #1;
        end
        check("hold_out_stable", 64'(bad), 64'(0));
        check("hold_no_mul_start", 64'(starts), 64'(0));
        bus.out_ready = 1'b1;
        wait_all("hold_done", 300);

        // Timeout: done never drops, so WAIT_LOW must abort after TIMEOUT_CYCLES.
        stub_done_high = 1'b1;
        push(32'd3, 32'd3, '{64'd0, 5'd0, 5'd0, 1'b1});
        k = 0;
        while (!bus.mul_start && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("to_launch_seen", 64'(bus.mul_start), 64'(1));
        dwell = 0;
        k     = 0;
        while (!bus.out_valid && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (!bus.mul_start && !bus.out_valid) dwell++;
        end
        check("to_wait_low_dwell", 64'(dwell), 64'(TIMEOUT_CYCLES));
        wait_all("to_done", 50);
        stub_done_high = 1'b0;
        push(32'hFFFF_FFFA, 32'd11, expect_of(32'hFFFF_FFFA, 32'd11));
        wait_all("after_to_done", 200);

        // Reset while the multiplier is mid-computation.
        push(32'd7, 32'd9, expect_of(32'd7, 32'd9));
        k = 0;
        while (!(bus.busy && !bus.mul_done && !bus.mul_start) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("reached_wait_high", 64'(bus.busy && !bus.mul_done), 64'(1));
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_mul_start", 64'(bus.mul_start), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        check("midrst_mul_a", 64'(bus.mul_a), 64'(0));
        check("midrst_out_product", bus.out_product, 64'(0));
        sb_q.delete();
        n_pushed = n_results;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(32'hFFFF_FFFC, 32'hFFFF_FFFC, '{64'd16, 5'd0, 5'd1, 1'b0});
        wait_all("post_rst_done", 200);
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
